// File: rtl/mem_stage_hs_if.sv
// mem_stage_hs_if: variable-latency data bus between the MEM stage (master)
// and memory (slave).
//   bus_req   master->slave  access request, held until bus_ack
//   bus_we    master->slave  1 = write
//   bus_addr  master->slave  word-aligned byte address
//   bus_be    master->slave  byte enables
//   bus_wdata master->slave  lane-replicated store data
//   bus_ack   slave->master  access complete, bus_rdata valid this cycle
//   bus_rdata slave->master  read word
interface mem_stage_hs_if #(
  parameter int AW = 32
) ();
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_be;
  logic [31:0]   bus_wdata;
  logic          bus_ack;
  logic [31:0]   bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: pipeline MEM stage with a req/ack data bus.
//   Inputs : EX/MEM bundle (in_valid, alu_s, mem_wdata, write_reg, mem_read,
//            mem_write, mem_size, mem_unsigned, reg_write, mem_to_reg,
//            pc_plus4, lu_op, lu_data).
//   stall_o: stall_out holds upstream while an access is outstanding.
//   bus    : mem_stage_hs_if master modport (registered request side).
//   Outputs: MEM/WB bundle (wb_valid, wb_data, wb_reg, wb_regwrite) and the
//            one-cycle exception pulses exc_misalign / exc_buserr.
module mem_stage_hs #(
  parameter int AW     = 32,
  parameter int RW     = 5,
  parameter int TO_CYC = 64
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          in_valid,
  input  logic [AW-1:0] alu_s,
  input  logic [31:0]   mem_wdata,
  input  logic [RW-1:0] write_reg,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [1:0]    mem_size,
  input  logic          mem_unsigned,
  input  logic          reg_write,
  input  logic [1:0]    mem_to_reg,
  input  logic [AW-1:0] pc_plus4,
  input  logic          lu_op,
  input  logic [31:0]   lu_data,
  output logic          stall_out,
  mem_stage_hs_if.master bus,
  output logic          wb_valid,
  output logic [31:0]   wb_data,
  output logic [RW-1:0] wb_reg,
  output logic          wb_regwrite,
  output logic          exc_misalign,
  output logic          exc_buserr
);
  localparam int CW = $clog2(TO_CYC + 1);
  localparam int NB = (AW < 32) ? AW : 32;

  typedef enum logic {IDLE, BUSY} state_t;

  // Zero-extend or truncate an AW-bit value to 32 bits.
  function automatic logic [31:0] to32(input logic [AW-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NB-1:0] = v[NB-1:0];
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic        [31:0] r;
    b  = rd[8*a +: 8];
    h  = a[1] ? rd[31:16] : rd[15:0];
    sb = signed'(b);
    sh = signed'(h);
    case (sz)
      2'b00:   r = uns ? {24'h0, b} : 32'(sb);
      2'b01:   r = uns ? {16'h0, h} : 32'(sh);
      default: r = rd;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a, input logic we);
    logic [3:0] r;
    if (!we)               r = 4'b1111;
    else if (sz == 2'b00)  r = 4'b0001 << a;
    else if (sz == 2'b01)  r = a[1] ? 4'b1100 : 4'b0011;
    else                   r = 4'b1111;
    return r;
  endfunction

  function automatic logic [31:0] lane_wd(input logic [1:0] sz, input logic [31:0] wd, input logic we);
    logic [31:0] r;
    if (!we)               r = '0;
    else if (sz == 2'b00)  r = {4{wd[7:0]}};
    else if (sz == 2'b01)  r = {2{wd[15:0]}};
    else                   r = wd;
    return r;
  endfunction

  function automatic logic [31:0] wb_sel(input logic lu, input logic [31:0] lud, input logic [1:0] m2r,
                                         input logic [AW-1:0] alu, input logic [31:0] ld,
                                         input logic [AW-1:0] pc);
    logic [31:0] r;
    if (lu)                r = lud;
    else if (m2r == 2'b00) r = to32(alu);
    else if (m2r == 2'b01) r = ld;
    else                   r = to32(pc);
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]      bus_be_q, bus_be_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  logic            wb_valid_q, wb_valid_d, wb_regwrite_q, wb_regwrite_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [RW-1:0]   wb_reg_q, wb_reg_d;
  logic            exc_mis_q, exc_mis_d, exc_bus_q, exc_bus_d;
  logic            cap_en;

  // Instruction fields held while the bus access is outstanding.
  logic [RW-1:0]   rd_q;
  logic            rw_q, lu_q, uns_q;
  logic [1:0]      m2r_q, sz_q;
  logic [31:0]     lud_q;
  logic [AW-1:0]   alu_q, pc_q;

  logic memop, mis, to_hit;

  assign memop  = in_valid & (mem_read | mem_write);
  assign mis    = ((mem_size == 2'b01) & alu_s[0]) | (mem_size[1] & (alu_s[1:0] != 2'b00));
  // Current BUSY cycle is the TO_CYC-th one.
  assign to_hit = (cnt_q == CW'(TO_CYC - 1));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_out     = 1'b0;
    cap_en        = 1'b0;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_be_d      = bus_be_q;
    bus_wdata_d   = bus_wdata_q;
    wb_valid_d    = 1'b0;
    wb_regwrite_d = 1'b0;
    wb_data_d     = wb_data_q;
    wb_reg_d      = wb_reg_q;
    exc_mis_d     = 1'b0;
    exc_bus_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (memop && !mis) begin
          stall_out   = 1'b1;
          cap_en      = 1'b1;
          state_d     = BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = {alu_s[AW-1:2], 2'b00};
          bus_be_d    = lane_be(mem_size, alu_s[1:0], mem_write);
          bus_wdata_d = lane_wd(mem_size, mem_wdata, mem_write);
        end else begin
          // Non-memop or misaligned access; a misaligned one never writes a register.
          wb_valid_d    = in_valid;
          wb_regwrite_d = reg_write & in_valid & ~memop;
          wb_reg_d      = write_reg;
          wb_data_d     = wb_sel(lu_op, lu_data, mem_to_reg, alu_s, 32'h0, pc_plus4);
          exc_mis_d     = memop;
        end
      end
      BUSY: begin
        stall_out = ~bus.bus_ack & ~to_hit;
        cnt_d     = cnt_q + CW'(1);
        if (bus.bus_ack) begin
          state_d       = IDLE;
          bus_req_d     = 1'b0;
          wb_valid_d    = 1'b1;
          wb_regwrite_d = rw_q;
          wb_reg_d      = rd_q;
          wb_data_d     = wb_sel(lu_q, lud_q, m2r_q, alu_q,
                                 load_ext(bus.bus_rdata, alu_q[1:0], sz_q, uns_q), pc_q);
        end else if (to_hit) begin
          state_d    = IDLE;
          bus_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_reg_d   = rd_q;
          exc_bus_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_be_q      <= '0;
      bus_wdata_q   <= '0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_data_q     <= '0;
      wb_reg_q      <= '0;
      exc_mis_q     <= 1'b0;
      exc_bus_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_be_q      <= bus_be_d;
      bus_wdata_q   <= bus_wdata_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_data_q     <= wb_data_d;
      wb_reg_q      <= wb_reg_d;
      exc_mis_q     <= exc_mis_d;
      exc_bus_q     <= exc_bus_d;
    end
  end

  // Capture stage: fields are only consumed in BUSY, so they need no reset.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      rd_q  <= write_reg;
      rw_q  <= reg_write & in_valid;
      lu_q  <= lu_op;
      lud_q <= lu_data;
      m2r_q <= mem_to_reg;
      alu_q <= alu_s;
      pc_q  <= pc_plus4;
      sz_q  <= mem_size;
      uns_q <= mem_unsigned;
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_data       = wb_data_q;
  assign wb_reg        = wb_reg_q;
  assign wb_regwrite   = wb_regwrite_q;
  assign exc_misalign  = exc_mis_q;
  assign exc_buserr    = exc_bus_q;
endmodule

// File: tb/tb_mem_stage_hs.sv
module tb_mem_stage_hs;
  localparam int AW     = 32;
  localparam int RW     = 5;
  localparam int TO_CYC = 4;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          in_valid, mem_read, mem_write, mem_unsigned, reg_write, lu_op;
  logic [AW-1:0] alu_s, pc_plus4;
  logic [31:0]   mem_wdata, lu_data;
  logic [RW-1:0] write_reg;
  logic [1:0]    mem_size, mem_to_reg;
  logic          stall_out, wb_valid, wb_regwrite, exc_misalign, exc_buserr;
  logic [31:0]   wb_data;
  logic [RW-1:0] wb_reg;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_stage_hs_if #(.AW(AW)) bus ();

  mem_stage_hs #(.AW(AW), .RW(RW), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .reset_b(reset_b), .in_valid(in_valid), .alu_s(alu_s), .mem_wdata(mem_wdata),
    .write_reg(write_reg), .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .pc_plus4(pc_plus4), .lu_op(lu_op), .lu_data(lu_data), .stall_out(stall_out),
    .bus(bus.master), .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg(wb_reg),
    .wb_regwrite(wb_regwrite), .exc_misalign(exc_misalign), .exc_buserr(exc_buserr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    in_valid = 0; mem_read = 0; mem_write = 0; mem_unsigned = 0; reg_write = 0; lu_op = 0;
    alu_s = '0; pc_plus4 = '0; mem_wdata = '0; lu_data = '0; write_reg = '0;
    mem_size = 2'b00; mem_to_reg = 2'b00;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
  endtask

  task automatic set_mem(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] dst,
                         input logic rw);
    in_valid = 1; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    alu_s = addr; mem_wdata = wd; write_reg = dst; reg_write = rw; lu_op = 0;
    mem_to_reg = rd ? 2'b01 : 2'b00;
  endtask

  // Load acknowledged in the first BUSY cycle.
  task automatic quick_load(input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                            input logic [31:0] rdata);
    set_mem(1'b1, 1'b0, sz, uns, addr, 32'h0, 5'd6, 1'b1);
    step;
    bus.bus_ack = 1'b1; bus.bus_rdata = rdata;
    step;
    clr_in;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time observed beyond limit expected finish");
    $fatal(1);
  end

  initial begin
    clr_in;
    reset_b = 1'b0;
    #3;
    chk("rst_req", 32'(bus.bus_req), 32'h0);
    chk("rst_wbv", 32'(wb_valid), 32'h0);
    chk("rst_wbd", wb_data, 32'h0);
    chk("rst_exc", {30'h0, exc_misalign, exc_buserr}, 32'h0);
    chk("rst_stall", 32'(stall_out), 32'h0);
    step;
    reset_b = 1'b1;
    step;

    // ALU op, LUI and link selection
    in_valid = 1; alu_s = 32'h1234; write_reg = 5'd3; reg_write = 1; mem_to_reg = 2'b00;
    #1 chk("alu_stall", 32'(stall_out), 32'h0);
    step;
    chk("alu_wbd", wb_data, 32'h1234);
    chk("alu_wbr", 32'(wb_reg), 32'd3);
    chk("alu_wbw", {30'h0, wb_valid, wb_regwrite}, 32'h3);
    lu_op = 1; lu_data = 32'hABCD_0000; mem_to_reg = 2'b10;
    step;
    chk("lui_wbd", wb_data, 32'hABCD_0000);
    lu_op = 0; pc_plus4 = 32'h44;
    step;
    chk("pc4_wbd", wb_data, 32'h44);
    clr_in;
    step;
    chk("bub_wbv", {30'h0, wb_valid, wb_regwrite}, 32'h0);

    // Signed byte load, ack in third BUSY cycle
    set_mem(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd5, 1'b1);
    #1 chk("lb_stall0", 32'(stall_out), 32'h1);
    step;
    chk("lb_req", 32'(bus.bus_req), 32'h1);
    chk("lb_addr", bus.bus_addr, 32'h100);
    chk("lb_be_we", {27'h0, bus.bus_be, bus.bus_we}, {27'h0, 4'hF, 1'b0});
    chk("lb_wdata", bus.bus_wdata, 32'h0);
    chk("lb_wbv_busy", 32'(wb_valid), 32'h0);
    chk("lb_stall1", 32'(stall_out), 32'h1);
    step;
    chk("lb_stall2", 32'(stall_out), 32'h1);
    step;
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h80AA_BBCC;
    #1 chk("lb_stall_ack", 32'(stall_out), 32'h0);
    step;
    clr_in;
    chk("lb_wbd", wb_data, 32'hFFFF_FF80);
    chk("lb_wbr", 32'(wb_reg), 32'd5);
    chk("lb_wbw", {30'h0, wb_valid, wb_regwrite}, 32'h3);
    chk("lb_req_done", 32'(bus.bus_req), 32'h0);

    quick_load(32'h101, 2'b00, 1'b1, 32'h1234_5678);
    chk("lbu_wbd", wb_data, 32'h0000_0056);
    quick_load(32'h102, 2'b01, 1'b0, 32'h8001_0000);
    chk("lh_wbd", wb_data, 32'hFFFF_8001);
    quick_load(32'h102, 2'b01, 1'b1, 32'h8001_0000);
    chk("lhu_wbd", wb_data, 32'h0000_8001);
    quick_load(32'h104, 2'b11, 1'b0, 32'hCAFE_F00D);
    chk("lw11_wbd", wb_data, 32'hCAFE_F00D);

    // Stores
    set_mem(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'hDEAD_BEEF, 5'd0, 1'b0);
    step;
    chk("sh_be", 32'(bus.bus_be), 32'hC);
    chk("sh_wdata", bus.bus_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", bus.bus_addr, 32'h200);
    chk("sh_req_we", {30'h0, bus.bus_req, bus.bus_we}, 32'h3);
    bus.bus_ack = 1'b1;
    #1 chk("sh_stall_ack", 32'(stall_out), 32'h0);
    step;
    clr_in;
    chk("sh_req_done", 32'(bus.bus_req), 32'h0);
    chk("sh_wbw", {30'h0, wb_valid, wb_regwrite}, 32'h2);
    set_mem(1'b0, 1'b1, 2'b00, 1'b0, 32'h203, 32'h0000_00A5, 5'd0, 1'b0);
    step;
    chk("sb_be", 32'(bus.bus_be), 32'h8);
    chk("sb_wdata", bus.bus_wdata, 32'hA5A5_A5A5);
    bus.bus_ack = 1'b1;
    step;
    clr_in;
    set_mem(1'b0, 1'b1, 2'b10, 1'b0, 32'h204, 32'h1357_9BDF, 5'd0, 1'b0);
    step;
    chk("sw_be", 32'(bus.bus_be), 32'hF);
    chk("sw_wdata", bus.bus_wdata, 32'h1357_9BDF);
    bus.bus_ack = 1'b1;
    step;
    clr_in;

    // Misaligned accesses
    set_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd7, 1'b1);
    #1 chk("mis_stall", 32'(stall_out), 32'h0);
    step;
    clr_in;
    chk("mis_req", 32'(bus.bus_req), 32'h0);
    chk("mis_exc", 32'(exc_misalign), 32'h1);
    chk("mis_wbw", {30'h0, wb_valid, wb_regwrite}, 32'h2);
    step;
    chk("mis_pulse", 32'(exc_misalign), 32'h0);
    set_mem(1'b0, 1'b1, 2'b01, 1'b0, 32'h103, 32'h0, 5'd0, 1'b0);
    step;
    clr_in;
    chk("mis_sh_exc", {30'h0, exc_misalign, bus.bus_req}, 32'h2);

    // Timeout after TO_CYC BUSY cycles
    set_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 5'd8, 1'b1);
    step;
    chk("to_stall_c1", 32'(stall_out), 32'h1);
    step;
    step;
    chk("to_stall_c3", 32'(stall_out), 32'h1);
    step;
    chk("to_stall_c4", 32'(stall_out), 32'h0);
    chk("to_req_c4", {30'h0, bus.bus_req, exc_buserr}, 32'h2);
    clr_in;
    step;
    chk("to_exc", 32'(exc_buserr), 32'h1);
    chk("to_req", 32'(bus.bus_req), 32'h0);
    chk("to_wbw", {30'h0, wb_valid, wb_regwrite}, 32'h2);
    step;
    chk("to_pulse", {30'h0, exc_buserr, wb_valid}, 32'h0);

    // Ack coincident with the TO_CYC-th cycle wins
    set_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd9, 1'b1);
    step;
    step;
    step;
    step;
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h1122_3344;
    #1 chk("co_stall", 32'(stall_out), 32'h0);
    step;
    clr_in;
    chk("co_wbd", wb_data, 32'h1122_3344);
    chk("co_wbw", {29'h0, wb_valid, wb_regwrite, exc_buserr}, 32'h6);

    // Reset while BUSY
    set_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 5'd10, 1'b1);
    step;
    chk("rb_req_busy", 32'(bus.bus_req), 32'h1);
    clr_in;
    #2 reset_b = 1'b0;
    #1;
    chk("rb_req", 32'(bus.bus_req), 32'h0);
    chk("rb_addr", bus.bus_addr, 32'h0);
    chk("rb_wb", {29'h0, wb_valid, wb_regwrite, stall_out}, 32'h0);
    step;
    reset_b = 1'b1;
    step;
    chk("rb_nowb", {30'h0, wb_valid, bus.bus_req}, 32'h0);
    in_valid = 1; alu_s = 32'h55; write_reg = 5'd1; reg_write = 1;
    #1 chk("rb_idle_stall", 32'(stall_out), 32'h0);
    step;
    clr_in;
    chk("rb_idle_wbd", wb_data, 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
